// File: rtl/map_table_ckpt_pkg.sv
// Purpose: shared types and sizing for the checkpointed rename map table.
// Contents: tag/index widths, map entry and CDB payload structs, identity map helper.
package map_table_ckpt_pkg;

  localparam int unsigned N_LANES      = 2;
  localparam int unsigned NUM_ARCH     = 8;
  localparam int unsigned NUM_PHYS     = 64;
  localparam int unsigned NUM_CKPT_DEF = 4;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_IDX_W    = $clog2(NUM_ARCH);
  localparam int unsigned PHYS_TAG_W   = $clog2(NUM_PHYS);
  localparam int unsigned CKPT_IDX_W   = $clog2(NUM_CKPT_DEF);

  typedef logic [REG_IDX_W-1:0]  reg_idx_t;
  typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
  typedef logic [CKPT_IDX_W-1:0] ckpt_idx_t;

  typedef struct packed {
    phys_tag_t phys_reg;
    logic      ready;
  } map_entry_t;

  typedef struct packed {
    logic            valid;
    phys_tag_t       tag;
    logic [XLEN-1:0] data;
  } cdb_entry_t;

  typedef map_entry_t [NUM_ARCH-1:0] map_table_t;

  // Reset image: arch i maps to phys i, already ready.
  function automatic map_table_t identity_map();
    map_table_t t;
    for (int i = 0; i < int'(NUM_ARCH); i++) begin
      t[i].phys_reg = PHYS_TAG_W'(i);
      t[i].ready    = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/map_table_ckpt_if.sv
// Purpose: bundle of rename/CDB/checkpoint signals between the pipeline and the map table.
// master: dispatch, CDB and branch unit side; slave: the map table.
interface map_table_ckpt_if
  import map_table_ckpt_pkg::*;
#(
  parameter int unsigned WIDTH      = N_LANES,
  parameter int unsigned READ_PORTS = 2 * N_LANES,
  parameter int unsigned CDB_PORTS  = N_LANES,
  parameter int unsigned NUM_CKPT   = NUM_CKPT_DEF
);
  localparam int unsigned LANE_W = $clog2(WIDTH + 1);
  localparam int unsigned CKPT_W = $clog2(NUM_CKPT);
  localparam int unsigned CNT_W  = $clog2(NUM_CKPT + 1);

  logic [WIDTH-1:0]  write_enables;
  reg_idx_t          write_addrs     [WIDTH];
  phys_tag_t         write_phys_regs [WIDTH];
  reg_idx_t          read_addrs      [READ_PORTS];
  map_entry_t        read_entries    [READ_PORTS];
  cdb_entry_t        cdb_broadcasts  [CDB_PORTS];
  logic              ckpt_req;
  logic [LANE_W-1:0] ckpt_lane;
  logic              ckpt_ack;
  logic [CKPT_W-1:0] ckpt_id;
  logic              restore_valid;
  logic [CKPT_W-1:0] restore_id;
  logic              free_valid;
  logic [CNT_W-1:0]  ckpt_count;
  logic              ckpt_full;

  modport master (
    output write_enables, write_addrs, write_phys_regs, read_addrs, cdb_broadcasts,
           ckpt_req, ckpt_lane, restore_valid, restore_id, free_valid,
    input  read_entries, ckpt_ack, ckpt_id, ckpt_count, ckpt_full
  );

  modport slave (
    input  write_enables, write_addrs, write_phys_regs, read_addrs, cdb_broadcasts,
           ckpt_req, ckpt_lane, restore_valid, restore_id, free_valid,
    output read_entries, ckpt_ack, ckpt_id, ckpt_count, ckpt_full
  );

endinterface

// File: rtl/map_table_next.sv
// Purpose: combinational next image of a map table: CDB wakeups, then rename writes
// of lanes below i_lane_limit (higher lane wins, a write clears ready).
// Ports: i_table in, i_wr_en/i_wr_addr/i_wr_phys lanes, i_cdb_valid/i_cdb_tag wakeups,
//        i_lane_limit lanes considered, o_table result.
module map_table_next
  import map_table_ckpt_pkg::*;
#(
  parameter int unsigned WIDTH     = N_LANES,
  parameter int unsigned CDB_PORTS = N_LANES
) (
  input  map_table_t                   i_table,
  input  logic [WIDTH-1:0]             i_wr_en,
  input  reg_idx_t                     i_wr_addr [WIDTH],
  input  phys_tag_t                    i_wr_phys [WIDTH],
  input  logic [CDB_PORTS-1:0]         i_cdb_valid,
  input  phys_tag_t                    i_cdb_tag [CDB_PORTS],
  input  logic [$clog2(WIDTH+1)-1:0]   i_lane_limit,
  output map_table_t                   o_table
);
  localparam int unsigned LANE_W = $clog2(WIDTH + 1);

  // Wakeups match the incoming tags; writes come after so they override them.
  always_comb begin
    o_table = i_table;
    for (int a = 0; a < int'(NUM_ARCH); a++) begin
      for (int c = 0; c < int'(CDB_PORTS); c++) begin
        if (i_cdb_valid[c] && (i_table[a].phys_reg == i_cdb_tag[c])) o_table[a].ready = 1'b1;
      end
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i_wr_en[i] && (LANE_W'(i) < i_lane_limit)) begin
        o_table[i_wr_addr[i]].phys_reg = i_wr_phys[i];
        o_table[i_wr_addr[i]].ready    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/map_table_ckpt.sv
// Purpose: rename map table with ready bits and a circular buffer of snapshots for
// single-cycle mispredict recovery.
// Ports: clock, reset (async, active-high), bus (slave): rename writes, reads,
//        CDB wakeups, checkpoint take/restore/free and occupancy status.
module map_table_ckpt
  import map_table_ckpt_pkg::*;
#(
  parameter int unsigned WIDTH      = N_LANES,
  parameter int unsigned READ_PORTS = 2 * N_LANES,
  parameter int unsigned CDB_PORTS  = N_LANES,
  parameter int unsigned NUM_CKPT   = NUM_CKPT_DEF
) (
  input logic            clock,
  input logic            reset,
  map_table_ckpt_if.slave bus
);
  localparam int unsigned CKPT_W = $clog2(NUM_CKPT);
  localparam int unsigned PTR_W  = CKPT_W + 1;
  localparam int unsigned CNT_W  = $clog2(NUM_CKPT + 1);
  localparam int unsigned LANE_W = $clog2(WIDTH + 1);

  map_table_t r_live;
  map_table_t r_snap [NUM_CKPT];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;

  map_table_t           w_live_next;
  map_table_t           w_snap_img;
  map_table_t           w_snap_cdb [NUM_CKPT];
  logic [WIDTH-1:0]     w_wr_en;
  logic [CDB_PORTS-1:0] w_cdb_valid;
  phys_tag_t            w_cdb_tag [CDB_PORTS];
  logic                 w_unused_cdb_data;
  logic [CKPT_W-1:0]    w_dist_idx;
  logic [PTR_W-1:0]     w_dist;
  logic [PTR_W-1:0]     w_count;
  logic [PTR_W-1:0]     w_head_next;
  logic [PTR_W-1:0]     w_tail_next;
  logic                 w_full;
  logic                 w_ack;

  // CDB payload data is not needed here; only valid and tag matter.
  always_comb begin
    w_unused_cdb_data = 1'b0;
    for (int c = 0; c < int'(CDB_PORTS); c++) begin
      w_cdb_valid[c]    = bus.cdb_broadcasts[c].valid;
      w_cdb_tag[c]      = bus.cdb_broadcasts[c].tag;
      w_unused_cdb_data = w_unused_cdb_data ^ (^bus.cdb_broadcasts[c].data);
    end
  end

  function automatic map_table_t cdb_apply(input map_table_t t,
                                           input logic [CDB_PORTS-1:0] v,
                                           input phys_tag_t tg [CDB_PORTS]);
    map_table_t r = t;
    for (int a = 0; a < int'(NUM_ARCH); a++) begin
      for (int c = 0; c < int'(CDB_PORTS); c++) begin
        if (v[c] && (t[a].phys_reg == tg[c])) r[a].ready = 1'b1;
      end
    end
    return r;
  endfunction

  // Occupancy from pointers with an extra wrap bit so full and empty differ.
  assign w_count     = r_tail - r_head;
  assign w_full      = (w_count == PTR_W'(NUM_CKPT));
  assign w_ack       = bus.ckpt_req & ~w_full & ~bus.restore_valid;
  assign w_wr_en     = bus.restore_valid ? '0 : bus.write_enables;
  assign w_dist_idx  = bus.restore_id - r_head[CKPT_W-1:0];
  assign w_dist      = {1'b0, w_dist_idx};

  assign bus.ckpt_ack   = w_ack;
  assign bus.ckpt_id    = r_tail[CKPT_W-1:0];
  assign bus.ckpt_count = CNT_W'(w_count);
  assign bus.ckpt_full  = w_full;

  // Live table reads: no bypass of this cycle's updates.
  always_comb begin
    for (int p = 0; p < int'(READ_PORTS); p++) bus.read_entries[p] = r_live[bus.read_addrs[p]];
  end

  map_table_next #(.WIDTH(WIDTH), .CDB_PORTS(CDB_PORTS)) u_live_next (
    .i_table      (r_live),
    .i_wr_en      (w_wr_en),
    .i_wr_addr    (bus.write_addrs),
    .i_wr_phys    (bus.write_phys_regs),
    .i_cdb_valid  (w_cdb_valid),
    .i_cdb_tag    (w_cdb_tag),
    .i_lane_limit (LANE_W'(WIDTH)),
    .o_table      (w_live_next)
  );

  map_table_next #(.WIDTH(WIDTH), .CDB_PORTS(CDB_PORTS)) u_snap_next (
    .i_table      (r_live),
    .i_wr_en      (w_wr_en),
    .i_wr_addr    (bus.write_addrs),
    .i_wr_phys    (bus.write_phys_regs),
    .i_cdb_valid  (w_cdb_valid),
    .i_cdb_tag    (w_cdb_tag),
    .i_lane_limit (bus.ckpt_lane),
    .o_table      (w_snap_img)
  );

  // Stored snapshots keep tracking wakeups so a restore sees current readiness.
  for (genvar s = 0; s < int'(NUM_CKPT); s++) begin : g_snap_cdb
    assign w_snap_cdb[s] = cdb_apply(r_snap[s], w_cdb_valid, w_cdb_tag);
  end

  // Restore rewinds tail to the restored slot; a coincident free of that same
  // slot leaves the buffer empty with tail == head.
  always_comb begin
    w_head_next = r_head + PTR_W'(bus.free_valid);
    w_tail_next = r_tail + PTR_W'(w_ack);
    if (bus.restore_valid) begin
      w_tail_next = r_head + w_dist;
      if (bus.free_valid && (w_dist == '0)) w_tail_next = w_head_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_live <= identity_map();
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_live <= bus.restore_valid ? w_snap_cdb[bus.restore_id] : w_live_next;
      r_head <= w_head_next;
      r_tail <= w_tail_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < int'(NUM_CKPT); s++) r_snap[s] <= identity_map();
    end else begin
      for (int s = 0; s < int'(NUM_CKPT); s++) begin
        if (w_ack && (r_tail[CKPT_W-1:0] == CKPT_W'(s))) r_snap[s] <= w_snap_img;
        else                                             r_snap[s] <= w_snap_cdb[s];
      end
    end
  end

  a_free_nonempty: assert property (@(posedge clock) disable iff (reset)
    bus.free_valid |-> (w_count != '0))
    else $error("free with no live checkpoint");

  a_restore_live: assert property (@(posedge clock) disable iff (reset)
    bus.restore_valid |-> (w_dist < w_count))
    else $error("restore of a non-live checkpoint");

endmodule

// File: doc/map_table_ckpt.md
# map_table_ckpt

Parametrised register map table with branch checkpointing: an N-wide rename mapping from architectural to physical tags, with ready bits maintained from CDB broadcasts. It keeps a circular buffer of map snapshots so that a branch mispredict restores the whole table in one cycle. It sits between dispatch/rename (writes and reads), the CDB (ready updates) and branch resolution (restore/free), and replaces the plain map table.

## Interface
Parameters:
- WIDTH, default `N: rename lanes (write ports).
- READ_PORTS, default 2*`N: read ports.
- CDB_PORTS, default `N: CDB broadcast inputs.
- NUM_CKPT, default 4: snapshot slots. Must be a power of two, ≥2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; one clock, fixed polarity and synchronicity.
- write_enables  in  WIDTH  per-lane rename write.
- write_addrs  in  WIDTH×REG_IDX  architectural destination.
- write_phys_regs  in  WIDTH×PHYS_TAG  new physical tag.
- read_addrs  in  READ_PORTS×REG_IDX  lookup addresses.
- read_entries  out  READ_PORTS×MAP_ENTRY  {phys_reg, ready} of the live table, combinational.
- cdb_broadcasts  in  CDB_PORTS×CDB_ENTRY  {valid, tag, data}; data is unused.
- ckpt_req  in  1  take a snapshot this cycle.
- ckpt_lane  in  $clog2(WIDTH+1)  the snapshot includes writes of lanes < ckpt_lane.
- ckpt_ack  out  1  the snapshot was accepted this cycle.
- ckpt_id  out  CKPT_IDX  slot used (valid when ckpt_ack is high).
- restore_valid  in  1  mispredict: restore slot restore_id.
- restore_id  in  CKPT_IDX  slot to restore; must be live.
- free_valid  in  1  the oldest checkpoint has resolved correctly; release it.
- ckpt_count  out  $clog2(NUM_CKPT+1)  live checkpoints.
- ckpt_full  out  1  ckpt_count == NUM_CKPT.

## Operation
- **Reset:**
  - Live table maps arch i → phys i, ready = 1.
  - Snapshots are cleared to identity.
  - head = tail = 0; ckpt_count = 0; ckpt_full = 0; ckpt_ack = 0.
- **Reads:** read_entries[p] = live[read_addrs[p]]. There is no bypass of same-cycle writes or CDB updates.
- **Writes:** when write_enables[i] is set, live[write_addrs[i]] ← {write_phys_regs[i], ready = 0}. Same-cycle writes to the same arch register: the highest lane index wins.
- **CDB:** for each valid broadcast, every entry whose phys_reg == tag sets ready = 1. This applies to the live table and to all live snapshots.
  - A write to an entry in the same cycle overrides the CDB for that entry (ready = 0).
- **Checkpoint:** ckpt_ack = ckpt_req & !ckpt_full & !restore_valid; ckpt_id = tail.
  - On ack, snapshot[tail] ← live with the CDB updates and the writes of lanes < ckpt_lane applied, then tail++ (mod NUM_CKPT).
  - A free in the same cycle does not make room for the snapshot (no bypass of a full condition).
- **Restore** (highest priority):
  - live ← snapshot[restore_id], with this cycle's CDB updates applied.
  - All write_enables and ckpt_req in that cycle are ignored.
  - tail ← restore_id, which discards that slot and all younger slots.
- **Free:** head++. If it coincides with a restore, both apply; when restore_id == head, the resulting count is 0.
- **Count:** ckpt_count = tail − head (mod), with a separate wrap bit so that full and empty are distinguishable.
- **Illegal input:** free with count 0, or restore of a non-live slot, is an error; assert it in simulation. The state is then undefined.

## Timing
- Writes, CDB updates, snapshots and restores are visible on read_entries 1 cycle after the clock edge.
- ckpt_ack and ckpt_id are combinational in the request cycle.
- ckpt_count and ckpt_full update on the edge.
- Restore completes in 1 cycle. Rename may resume the cycle after restore_valid.
- Reset asserted mid-operation immediately forces the reset state, including the outputs derived from state.

## Structure
- Shared package (sys_defs): REG_IDX, PHYS_TAG, MAP_ENTRY, CDB_ENTRY, and the CKPT_IDX typedef sized from a `NUM_CKPT constant.
- One sub-module, `map_table_next`: combinational next-state function (table in, writes/CDB/lane limit in, table out). It is instanced once for the live table and once for the snapshot image.
- The snapshot CDB update is a generate loop over slots.

## Test plan
- Reset → reading arch 0..7 returns phys 0..7, ready = 1; ckpt_count = 0.
- Write arch 5→40; ckpt_req with ckpt_lane = 0; next cycle write arch 5→50; restore id 0 → arch 5 reads {40, 0}, ckpt_count = 0.
- Snapshot taken with arch 3→44 not ready; CDB tag 44 while the snapshot is live; restore → arch 3 reads {44, 1}.
- Same cycle: lanes 0 and 1 write arch 7→33 and arch 7→34; ckpt_lane = 1 → live arch 7 = 34, snapshot arch 7 = 33.
- Take NUM_CKPT checkpoints → ckpt_full = 1; a further req with free_valid gives ckpt_ack = 0; next cycle ckpt_ack = 1 and ckpt_id wraps to 0.
- CDB tag 60 plus a write arch 3→60 in the same cycle → arch 3 reads {60, 0}; restore_valid together with ckpt_req → ckpt_ack = 0 and the writes are dropped.
